// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: register read, immediate extension, forwarding and load-use stall into an ID/EX register
module decode_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              ctrl_regdst,
  input  logic              ctrl_link,
  input  logic              ctrl_alusrc,
  input  logic              ctrl_expand,
  input  logic              ctrl_regwrite,
  input  logic              ctrl_memread,
  input  logic              ctrl_uses_rs,
  input  logic              ctrl_uses_rt,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              fw_mem_we,
  input  logic [REG_AW-1:0] fw_mem_rd,
  input  logic [XLEN-1:0]   fw_mem_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs_data,
  output logic [XLEN-1:0]   out_rt_data,
  output logic [XLEN-1:0]   out_alu_b,
  output logic [XLEN-1:0]   out_imm,
  output logic [REG_AW-1:0] out_rw,
  output logic              out_regwrite,
  output logic              out_memread
);
  localparam logic [REG_AW-1:0] link_idx = REG_AW'(LINK_REG);
  logic [XLEN-1:0] rf [2**REG_AW];
  logic [REG_AW-1:0] rs, rt, rd, rw;
  logic [15:0] imm;
  logic [XLEN-1:0] rs_val, rt_val, imm_ext;
  logic hazard, advance, unused;
  assign rs  = in_instr[21 +: REG_AW];
  assign rt  = in_instr[16 +: REG_AW];
  assign rd  = in_instr[11 +: REG_AW];
  assign imm = in_instr[15:0];
  assign unused = ^in_instr[31:26];
  // EX/MEM result is newer than the write-back value, so it wins
  assign rs_val = rs == '0 ? '0 : (fw_mem_we && fw_mem_rd == rs) ? fw_mem_data :
                  (wb_we && wb_rd == rs) ? wb_data : rf[rs];
  assign rt_val = rt == '0 ? '0 : (fw_mem_we && fw_mem_rd == rt) ? fw_mem_data :
                  (wb_we && wb_rd == rt) ? wb_data : rf[rt];
  assign imm_ext = ctrl_expand ? {{(XLEN-16){imm[15]}}, imm} : {{(XLEN-16){1'b0}}, imm};
  assign rw = ctrl_regdst ? rd : (ctrl_link ? link_idx : rt);
  assign hazard = in_valid && out_valid && out_memread && out_rw != '0 &&
                  ((ctrl_uses_rs && rs == out_rw) || (ctrl_uses_rt && rt == out_rw));
  assign advance  = !out_valid || ex_ready;
  assign in_ready = advance && !hazard && !flush && !reset;
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2**REG_AW; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      rf[wb_rd] <= wb_data;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs_data  <= '0;
      out_rt_data  <= '0;
      out_alu_b    <= '0;
      out_imm      <= '0;
      out_rw       <= '0;
      out_regwrite <= 1'b0;
      out_memread  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      if (in_valid && !hazard) begin
        out_valid    <= 1'b1;
        out_pc       <= in_pc;
        out_rs_data  <= rs_val;
        out_rt_data  <= rt_val;
        out_alu_b    <= ctrl_alusrc ? imm_ext : rt_val;
        out_imm      <= imm_ext;
        out_rw       <= rw;
        out_regwrite <= ctrl_regwrite && rw != '0;
        out_memread  <= ctrl_memread;
      end else if (in_valid) begin
        out_valid    <= 1'b0;
        out_regwrite <= 1'b0;
        out_memread  <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed vectors for the decode stage with hand-computed expectations
module tb_decode_stage_pipe;
  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        ctrl_regdst, ctrl_link, ctrl_alusrc, ctrl_expand, ctrl_regwrite, ctrl_memread;
  logic        ctrl_uses_rs, ctrl_uses_rt, flush, ex_ready, fw_mem_we, wb_we;
  logic [4:0]  fw_mem_rd, wb_rd, out_rw;
  logic [31:0] fw_mem_data, wb_data;
  logic        out_valid, out_regwrite, out_memread;
  logic [31:0] out_pc, out_rs_data, out_rt_data, out_alu_b, out_imm;
  int checks = 0;
  int errors = 0;

  decode_stage_pipe dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .ctrl_regdst(ctrl_regdst), .ctrl_link(ctrl_link),
    .ctrl_alusrc(ctrl_alusrc), .ctrl_expand(ctrl_expand), .ctrl_regwrite(ctrl_regwrite),
    .ctrl_memread(ctrl_memread), .ctrl_uses_rs(ctrl_uses_rs), .ctrl_uses_rt(ctrl_uses_rt),
    .flush(flush), .ex_ready(ex_ready), .fw_mem_we(fw_mem_we), .fw_mem_rd(fw_mem_rd),
    .fw_mem_data(fw_mem_data), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
    .out_alu_b(out_alu_b), .out_imm(out_imm), .out_rw(out_rw), .out_regwrite(out_regwrite),
    .out_memread(out_memread)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {6'd0, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_instr = 0; in_pc = 0;
    ctrl_regdst = 0; ctrl_link = 0; ctrl_alusrc = 0; ctrl_expand = 0;
    ctrl_regwrite = 0; ctrl_memread = 0; ctrl_uses_rs = 0; ctrl_uses_rt = 0;
    flush = 0; ex_ready = 1; fw_mem_we = 0; fw_mem_rd = 0; fw_mem_data = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_rw", {27'd0, out_rw}, 0);
    reset = 0;
    // write reg5, then ADD rs=5 rt=0 rd=9
    wb_we = 1; wb_rd = 5; wb_data = 32'h1234;
    step();
    idle();
    in_valid = 1; in_instr = ins(5, 0, 16'h4820); in_pc = 32'h100;
    ctrl_regdst = 1; ctrl_regwrite = 1; ctrl_uses_rs = 1; ctrl_uses_rt = 1;
    #1;
    chk("add_in_ready", {31'd0, in_ready}, 1);
    step();
    chk("add_valid", {31'd0, out_valid}, 1);
    chk("add_rs", out_rs_data, 32'h1234);
    chk("add_rt", out_rt_data, 0);
    chk("add_pc", out_pc, 32'h100);
    chk("add_rw", {27'd0, out_rw}, 9);
    chk("add_regwrite", {31'd0, out_regwrite}, 1);
    // same-cycle write-back is visible to the read
    idle();
    in_valid = 1; in_instr = ins(6, 5, 16'h0000); in_pc = 32'h104;
    wb_we = 1; wb_rd = 6; wb_data = 32'h55;
    step();
    chk("wb_bypass_rs", out_rs_data, 32'h55);
    chk("wb_bypass_rt", out_rt_data, 32'h1234);
    chk("alu_b_rt", out_alu_b, 32'h1234);
    // immediate extension, destination rt=4
    idle();
    in_valid = 1; in_instr = ins(0, 4, 16'hFFF0); in_pc = 32'h108;
    ctrl_alusrc = 1; ctrl_expand = 1; ctrl_regwrite = 1;
    step();
    chk("imm_sext", out_imm, 32'hFFFFFFF0);
    chk("alu_b_imm", out_alu_b, 32'hFFFFFFF0);
    chk("addi_rw", {27'd0, out_rw}, 4);
    ctrl_expand = 0;
    step();
    chk("imm_zext", out_imm, 32'h0000FFF0);
    // EX/MEM forwarding beats write-back
    idle();
    in_valid = 1; in_instr = ins(3, 0, 16'h0); in_pc = 32'h10C;
    fw_mem_we = 1; fw_mem_rd = 3; fw_mem_data = 32'hA;
    wb_we = 1; wb_rd = 3; wb_data = 32'hB;
    step();
    chk("fw_priority", out_rs_data, 32'hA);
    idle();
    in_valid = 1; in_instr = ins(3, 0, 16'h0); in_pc = 32'h110;
    step();
    chk("rf_after_wb", out_rs_data, 32'hB);
    // load-use: LW into 7, then consumer of rt=7
    idle();
    in_valid = 1; in_instr = ins(0, 7, 16'h0004); in_pc = 32'h114;
    ctrl_alusrc = 1; ctrl_expand = 1; ctrl_regwrite = 1; ctrl_memread = 1; ctrl_uses_rs = 1;
    step();
    chk("lw_memread", {31'd0, out_memread}, 1);
    chk("lw_rw", {27'd0, out_rw}, 7);
    idle();
    in_valid = 1; in_instr = ins(0, 7, 16'h5000); in_pc = 32'h118;
    ctrl_regdst = 1; ctrl_regwrite = 1; ctrl_uses_rs = 1; ctrl_uses_rt = 1;
    #1;
    chk("lu_stall_ready", {31'd0, in_ready}, 0);
    step();
    chk("lu_bubble_valid", {31'd0, out_valid}, 0);
    chk("lu_bubble_memread", {31'd0, out_memread}, 0);
    chk("lu_release_ready", {31'd0, in_ready}, 1);
    step();
    chk("lu_accept_valid", {31'd0, out_valid}, 1);
    chk("lu_accept_pc", out_pc, 32'h118);
    chk("lu_accept_rw", {27'd0, out_rw}, 10);
    // back-pressure holds the register, then flush clears it
    idle();
    in_valid = 1; in_instr = ins(5, 6, 16'h0); in_pc = 32'h11C; ex_ready = 0;
    #1;
    chk("bp_ready", {31'd0, in_ready}, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_pc", out_pc, 32'h118);
      chk("bp_hold_valid", {31'd0, out_valid}, 1);
    end
    flush = 1;
    #1;
    chk("flush_ready", {31'd0, in_ready}, 0);
    step();
    chk("flush_valid", {31'd0, out_valid}, 0);
    // reg0 ignores writes; JAL targets link register
    idle();
    wb_we = 1; wb_rd = 0; wb_data = 32'hFF;
    in_valid = 1; in_instr = ins(0, 0, 16'h0); in_pc = 32'h120;
    ctrl_link = 1; ctrl_regwrite = 1; ctrl_uses_rs = 1;
    step();
    chk("jal_rw", {27'd0, out_rw}, 31);
    chk("jal_regwrite", {31'd0, out_regwrite}, 1);
    chk("r0_same_cycle", out_rs_data, 0);
    idle();
    in_valid = 1; in_instr = ins(0, 0, 16'h0); in_pc = 32'h124;
    step();
    chk("r0_after_write", out_rs_data, 0);
    // write to rd=0 is suppressed
    idle();
    in_valid = 1; in_instr = ins(5, 0, 16'h0000); in_pc = 32'h128;
    ctrl_regdst = 1; ctrl_regwrite = 1;
    step();
    chk("rw0_regwrite", {31'd0, out_regwrite}, 0);
    // reset during a stall discards pipeline and regfile
    idle();
    in_valid = 1; in_instr = ins(5, 0, 16'h0); in_pc = 32'h12C; ex_ready = 0;
    reset = 1;
    step();
    chk("rst_mid_valid", {31'd0, out_valid}, 0);
    reset = 0;
    ex_ready = 1;
    step();
    chk("rst_rf_cleared", out_rs_data, 0);
    chk("rst_after_valid", {31'd0, out_valid}, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
